vliw_pc_unit: RTL and testbench
===============================

# vliw_pc_unit

Parametrised program-counter unit for the VLIW fetch stage, generalising the fixed 5-slot PC. It advances by one bundle per cycle and supports pipeline stall, branch/jump redirect, precise exception entry and return, and an optional circular return-address stack (RAS) for call/return. It sits at the head of fetch, and its `pc` output drives the instruction-memory bundle address.

## Interface
- `PC_W`, 32: PC width in bits.
- `SLOTS`, 5: instructions per bundle.
- `INST_BYTES`, 4: bytes per instruction. `BUNDLE_BYTES = SLOTS*INST_BYTES` is a derived localparam.
- `RESET_PC`, 32'h0040_0020: PC loaded at reset.
- `EXC_VECTOR`, 32'h0040_0000: exception handler entry.
- `RAS_DEPTH`, 4: RAS entries, minimum 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC.
- `redirect_valid` in 1: taken branch or jump.
- `redirect_pc` in PC_W: redirect target.
- `call_valid` in 1: the current redirect is a call. Only meaningful with `redirect_valid`.
- `ret_valid` in 1: return. Pops the RAS.
- `exc_valid` in 1: exception raised on the bundle at the current `pc`.
- `eret_valid` in 1: return from exception.
- `pc` out PC_W: current bundle address.
- `epc` out PC_W: saved exception PC.
- `ras_empty` out 1: RAS holds no entries.
- `ras_full` out 1: RAS holds RAS_DEPTH entries.
- `misalign` out 1: one-cycle pulse, a word-misaligned target was loaded.
- `ras_underflow` out 1: one-cycle pulse, `ret_valid` was asserted with the RAS empty.

## Operation
- Exactly one PC action happens per cycle, chosen by this priority: `exc_valid` > `eret_valid` > `ret_valid` > `redirect_valid` > `stall` > sequential.
- **Exception:** `epc <= pc`, `pc <= EXC_VECTOR`. The RAS is untouched. Exceptions override `stall`.
- **Eret:** `pc <= epc`.
- **Ret, RAS non-empty:** `pc <=` top-of-stack, then pop.
- **Ret, RAS empty:** `pc <= pc + BUNDLE_BYTES`, `ras_underflow` pulses, and the RAS is unchanged.
- **Redirect:** `pc <= {redirect_pc[PC_W-1:2], 2'b00}`.
  - `misalign` pulses if `redirect_pc[1:0] != 0`.
  - If `call_valid` is also asserted, push `pc + BUNDLE_BYTES`.
  - Redirect overrides `stall`.
- **Stall:** `pc` holds.
- **Sequential:** `pc <= pc + BUNDLE_BYTES`, unsigned modulo 2^PC_W. `pc` wraps from its top value to low addresses without any flag.
- `call_valid` without `redirect_valid` is ignored. `call_valid` is also ignored whenever a higher-priority action wins.
- **RAS structure:** circular buffer with a write pointer of `$clog2(RAS_DEPTH)` bits and an occupancy count saturating at RAS_DEPTH.
  - A push when full overwrites the oldest entry; the count stays at RAS_DEPTH.
  - A pop decrements the pointer and the count.
  - `ras_empty` = (count == 0); `ras_full` = (count == RAS_DEPTH).

## Timing
- All outputs are registered. Control inputs are sampled on the rising edge of `clk`, and `pc` and `epc` update on that same edge.
- Redirect latency is one cycle: a target presented in cycle N appears on `pc` in cycle N+1.
- `misalign` and `ras_underflow` are high for exactly the cycle after the triggering edge.
- While `rst_n` is low (asynchronously, including mid-sequence):
  - `pc = RESET_PC`, `epc = 0`.
  - RAS count = 0, pointer = 0, so `ras_empty = 1` and `ras_full = 0`.
  - `misalign = 0`, `ras_underflow = 0`.
- RAS entry contents are not reset.
- The first advance occurs on the first rising edge after `rst_n` deasserts.

## Configuration
- `PC_RAS_EN` defined: the RAS, `call_valid`/`ret_valid` handling, `ras_empty`, `ras_full` and `ras_underflow` are built as described above.
- `PC_RAS_EN` undefined: no RAS storage is built.
  - `call_valid` is ignored.
  - `ret_valid` is treated as a redirect to `redirect_pc`, at the same priority position.
  - `ras_empty` is tied to 1, `ras_full` to 0, and `ras_underflow` to 0.

## Test plan
- **Reset:** default parameters; hold `rst_n` low, then release and run 3 idle cycles → `pc` = 0x00400020, 0x00400034, 0x00400048, 0x0040005C. Asserting `rst_n` low mid-run returns `pc` to 0x00400020 immediately.
- **Stall vs redirect:** `stall`=1 for 2 cycles → `pc` holds. Then `stall`=1 with `redirect_valid`=1 and `redirect_pc`=0x00401003 → `pc` = 0x00401000 and `misalign` pulses once.
- **Exception/eret:** at `pc`=0x00400048, assert `exc_valid` together with `redirect_valid` → `pc` = 0x00400000, `epc` = 0x00400048. Later `eret_valid` → `pc` = 0x00400048.
- **RAS LIFO:** calls from 0x00400020 and 0x00500000, then 2 rets → `pc` = 0x00500014, then 0x00400034. A third ret → `pc` advances by 20 and `ras_underflow` pulses.
- **RAS overflow:** `RAS_DEPTH`=4; 5 calls with return addresses A1..A5 → `ras_full` = 1. Four rets yield A5, A4, A3, A2, and then `ras_empty` = 1.
- **Wrap and macro off:** `PC_W`=8, `RESET_PC`=8'hF0 → `pc` sequence 0xF0, 0x04. With `PC_RAS_EN` undefined, `ret_valid` with `redirect_pc`=0x40 → `pc` = 0x40 and `ras_empty` stays 1.

Source files
------------

// File: rtl/vliw_pc_unit.sv
// vliw_pc_unit: program counter for the VLIW fetch stage.
// Advances one bundle per cycle; handles stall, redirect, exception entry/return
// and an optional circular return-address stack.
// Optional feature macro: PC_RAS_EN (defined = RAS and call/return support built).
module vliw_pc_unit #(
   parameter int unsigned     PC_W       = 32,
   parameter int unsigned     SLOTS      = 5,
   parameter int unsigned     INST_BYTES = 4,
   parameter logic [PC_W-1:0] RESET_PC   = PC_W'(32'h0040_0020),
   parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0040_0000),
   parameter int unsigned     RAS_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            call_valid,
   input  logic            ret_valid,
   input  logic            exc_valid,
   input  logic            eret_valid,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] epc,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            misalign,
   output logic            ras_underflow
);

   localparam int unsigned     BUNDLE_BYTES = SLOTS * INST_BYTES;
   localparam logic [PC_W-1:0] PC_STEP      = PC_W'(BUNDLE_BYTES);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] epc_q, epc_d;
   logic            misalign_q, misalign_d;
   logic [PC_W-1:0] seq_pc_c;
   logic [PC_W-1:0] tgt_pc_c;

   assign seq_pc_c = pc_q + PC_STEP;
   assign tgt_pc_c = {redirect_pc[PC_W-1:2], 2'b00};

`ifdef PC_RAS_EN
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   logic [PC_W-1:0]  ras_mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] ras_wptr_q, ras_wptr_d;
   logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
   logic             ras_empty_q, ras_empty_d;
   logic             ras_full_q, ras_full_d;
   logic             ras_underflow_q, ras_underflow_d;
   logic             ras_wr_en_c;
   logic [PTR_W-1:0] ras_top_c;
   logic             ras_is_empty_c;
   logic             ras_is_full_c;

   assign ras_top_c      = (ras_wptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_wptr_q - PTR_W'(1);
   assign ras_is_empty_c = (ras_cnt_q == '0);
   assign ras_is_full_c  = (ras_cnt_q == CNT_W'(RAS_DEPTH));

   // Next PC / EPC / RAS bookkeeping by fixed action priority
   always_comb begin
      pc_d            = pc_q;
      epc_d           = epc_q;
      misalign_d      = 1'b0;
      ras_underflow_d = 1'b0;
      ras_wptr_d      = ras_wptr_q;
      ras_cnt_d       = ras_cnt_q;
      ras_wr_en_c     = 1'b0;
      if (exc_valid) begin
         epc_d = pc_q;
         pc_d  = EXC_VECTOR;
      end else if (eret_valid) begin
         pc_d = epc_q;
      end else if (ret_valid) begin
         if (ras_is_empty_c) begin
            pc_d            = seq_pc_c;
            ras_underflow_d = 1'b1;
         end else begin
            pc_d       = ras_mem_q[ras_top_c];
            ras_wptr_d = ras_top_c;
            ras_cnt_d  = ras_cnt_q - CNT_W'(1);
         end
      end else if (redirect_valid) begin
         pc_d       = tgt_pc_c;
         misalign_d = (redirect_pc[1:0] != 2'b00);
         if (call_valid) begin
            ras_wr_en_c = 1'b1;
            ras_wptr_d  = (ras_wptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_wptr_q + PTR_W'(1);
            // A push when full overwrites the oldest entry, count saturates
            ras_cnt_d   = ras_is_full_c ? ras_cnt_q : ras_cnt_q + CNT_W'(1);
         end
      end else if (!stall) begin
         pc_d = seq_pc_c;
      end
      ras_empty_d = (ras_cnt_d == '0);
      ras_full_d  = (ras_cnt_d == CNT_W'(RAS_DEPTH));
   end

   // RAS control state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ras_wptr_q      <= '0;
         ras_cnt_q       <= '0;
         ras_empty_q     <= 1'b1;
         ras_full_q      <= 1'b0;
         ras_underflow_q <= 1'b0;
      end else begin
         ras_wptr_q      <= ras_wptr_d;
         ras_cnt_q       <= ras_cnt_d;
         ras_empty_q     <= ras_empty_d;
         ras_full_q      <= ras_full_d;
         ras_underflow_q <= ras_underflow_d;
      end
   end

   // RAS storage, contents intentionally not reset
   always_ff @(posedge clk) begin
      if (ras_wr_en_c) ras_mem_q[ras_wptr_q] <= seq_pc_c;
   end

   assign ras_empty     = ras_empty_q;
   assign ras_full      = ras_full_q;
   assign ras_underflow = ras_underflow_q;
`else
   logic unused_call_c;

   assign unused_call_c = call_valid;

   // Next PC / EPC by fixed action priority; a return acts as a redirect
   always_comb begin
      pc_d       = pc_q;
      epc_d      = epc_q;
      misalign_d = 1'b0;
      if (exc_valid) begin
         epc_d = pc_q;
         pc_d  = EXC_VECTOR;
      end else if (eret_valid) begin
         pc_d = epc_q;
      end else if (ret_valid || redirect_valid) begin
         pc_d       = tgt_pc_c;
         misalign_d = (redirect_pc[1:0] != 2'b00);
      end else if (!stall) begin
         pc_d = seq_pc_c;
      end
   end

   assign ras_empty     = 1'b1;
   assign ras_full      = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   // PC, EPC and misalign pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         epc_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc       = pc_q;
   assign epc      = epc_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_vliw_pc_unit.sv
// tb_vliw_pc_unit: directed + randomized checks of vliw_pc_unit against a
// queue-based behavioural model. A second 8-bit instance covers PC wrap.
module tb_vliw_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0020;
   localparam logic [31:0] EXC_PC = 32'h0040_0000;
   localparam logic [31:0] BB     = 32'd20;
   localparam int          DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, redirect_valid = 1'b0, call_valid = 1'b0;
   logic        ret_valid = 1'b0, exc_valid = 1'b0, eret_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] pc, epc;
   logic        ras_empty, ras_full, misalign, ras_underflow;

   logic        ret8 = 1'b0;
   logic [7:0]  rpc8 = '0;
   logic [7:0]  pc8, epc8;
   logic        ras_empty8, ras_full8, misalign8, ras_underflow8;

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   logic [31:0] m_pc, m_epc;
   logic        m_mis, m_unf;
   logic [31:0] m_ras[$];

   vliw_pc_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .call_valid(call_valid), .ret_valid(ret_valid),
      .exc_valid(exc_valid), .eret_valid(eret_valid), .pc(pc), .epc(epc),
      .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign),
      .ras_underflow(ras_underflow)
   );

   vliw_pc_unit #(.PC_W(8), .RESET_PC(8'hF0), .EXC_VECTOR(8'h00)) dut8 (
      .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect_valid(1'b0),
      .redirect_pc(rpc8), .call_valid(1'b0), .ret_valid(ret8),
      .exc_valid(1'b0), .eret_valid(1'b0), .pc(pc8), .epc(epc8),
      .ras_empty(ras_empty8), .ras_full(ras_full8), .misalign(misalign8),
      .ras_underflow(ras_underflow8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_pc  = RST_PC;
      m_epc = '0;
      m_mis = 1'b0;
      m_unf = 1'b0;
      m_ras.delete();
   endtask

   task automatic idle();
      stall = 0; redirect_valid = 0; call_valid = 0;
      ret_valid = 0; exc_valid = 0; eret_valid = 0;
   endtask

   // Next model state from the current inputs, highest-priority action wins
   task automatic model_update();
      logic [31:0] old;
      old   = m_pc;
      m_mis = 1'b0;
      m_unf = 1'b0;
      if (exc_valid) begin
         m_epc = old;
         m_pc  = EXC_PC;
      end else if (eret_valid) begin
         m_pc = m_epc;
`ifdef PC_RAS_EN
      end else if (ret_valid) begin
         if (m_ras.size() > 0) m_pc = m_ras.pop_back();
         else begin
            m_pc  = old + BB;
            m_unf = 1'b1;
         end
      end else if (redirect_valid) begin
`else
      end else if (ret_valid || redirect_valid) begin
`endif
         m_pc  = redirect_pc & ~32'd3;
         m_mis = (redirect_pc % 4) != 0;
`ifdef PC_RAS_EN
         if (call_valid) begin
            m_ras.push_back(old + BB);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
`endif
      end else if (!stall) begin
         m_pc = old + BB;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".epc"}, epc, m_epc);
      chk({tag, ".mis"}, 32'(misalign), 32'(m_mis));
      chk({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
      chk({tag, ".empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
      chk({tag, ".full"}, 32'(ras_full), 32'(m_ras.size() == DEPTH));
   endtask

   // One clock: update model, take the edge, compare after it settles
   task automatic step(input string tag);
      model_update();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_all("rst");
      rst_n = 1'b1;
   endtask

   task automatic call_to(input logic [31:0] tgt, input string tag);
      idle();
      redirect_valid = 1; call_valid = 1; redirect_pc = tgt;
      step(tag);
      idle();
   endtask

   task automatic ret_once(input string tag);
      idle();
      ret_valid = 1;
      step(tag);
      idle();
   endtask

   initial begin
      logic [31:0] a [5];
      model_reset();
      idle();

      // reset and first advances, wrap on the 8-bit instance
      @(posedge clk);
      #1;
      check_all("rst0");
      chk("rst0.pc_abs", pc, 32'h0040_0020);
      chk("w8.rst", 32'(pc8), 32'hF0);
      rst_n = 1'b1;
      step("seq1");
      chk("w8.wrap", 32'(pc8), 32'h04);
      ret8 = 1; rpc8 = 8'h40;
      step("seq2");
`ifdef PC_RAS_EN
      chk("w8.ret", 32'(pc8), 32'h18);
      chk("w8.unf", 32'(ras_underflow8), 32'd1);
`else
      chk("w8.ret", 32'(pc8), 32'h40);
      chk("w8.unf", 32'(ras_underflow8), 32'd0);
`endif
      chk("w8.empty", 32'(ras_empty8), 32'd1);
      ret8 = 0;
      step("seq3");
      chk("seq3.pc_abs", pc, 32'h0040_005C);

      // asynchronous mid-cycle reset
      #2 rst_n = 1'b0;
      #1;
      chk("async.pc", pc, RST_PC);
      chk("async.empty", 32'(ras_empty), 32'd1);
      model_reset();
      #1 rst_n = 1'b1;

      // stall, then stall + misaligned redirect
      stall = 1;
      step("stall1");
      step("stall2");
      redirect_valid = 1; redirect_pc = 32'h0040_1003;
      step("redir");
      chk("redir.pc_abs", pc, 32'h0040_1000);
      chk("redir.mis_abs", 32'(misalign), 32'd1);
      idle();
      step("redir_after");

      // exception with competing redirect, then eret
      do_reset();
      step("e1");
      step("e2");
      exc_valid = 1; redirect_valid = 1; redirect_pc = 32'h1234_5678;
      step("exc");
      chk("exc.epc_abs", epc, 32'h0040_0048);
      idle();
      step("exc_idle");
      eret_valid = 1;
      step("eret");
      chk("eret.pc_abs", pc, 32'h0040_0048);
      idle();

`ifdef PC_RAS_EN
      // RAS LIFO and underflow
      do_reset();
      call_to(32'h0050_0000, "c1");
      call_to(32'h0060_0000, "c2");
      ret_once("r1");
      chk("r1.pc_abs", pc, 32'h0050_0014);
      ret_once("r2");
      chk("r2.pc_abs", pc, 32'h0040_0034);
      ret_once("r3");
      chk("r3.pc_abs", pc, 32'h0040_0048);
      chk("r3.unf_abs", 32'(ras_underflow), 32'd1);
      step("r3_after");

      // RAS overflow drops the oldest entry
      do_reset();
      for (int i = 0; i < 5; i++) begin
         a[i] = pc + BB;
         call_to(32'h0070_0000 + 32'(i) * 32'h100, "ovf_call");
      end
      chk("ovf.full_abs", 32'(ras_full), 32'd1);
      for (int i = 4; i >= 1; i--) begin
         ret_once("ovf_ret");
         chk("ovf.ret_abs", pc, a[i]);
      end
      chk("ovf.empty_abs", 32'(ras_empty), 32'd1);
`endif

      // randomized traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         exc_valid      = ($urandom_range(0, 99) < 3);
         eret_valid     = ($urandom_range(0, 99) < 5);
         ret_valid      = ($urandom_range(0, 99) < 15);
         redirect_valid = ($urandom_range(0, 99) < 30);
         call_valid     = ($urandom_range(0, 99) < 50);
         stall          = ($urandom_range(0, 99) < 20);
         redirect_pc    = $urandom;
         step("rand");
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
